// File: rtl/bcd_to_binary_seq.sv
// Multi-cycle BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional invalid-digit detection enabled by defining BCD_CHECK_EN.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binary,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ERR
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SR_W-1:0]    r_sreg, w_sreg_nxt, w_step;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_done, w_done_nxt;
  logic [BIN_W-1:0]   r_bin, w_bin_nxt;
  logic               w_invalid;
  logic               w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  // One reverse double-dabble step: shift right, then correct every BCD digit >= 8.
  // NOTE: combinational blocks use blocking '=' so later lines see the updated value.
  always_comb begin
    w_step = r_sreg >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_step[BIN_W+4*d +: 4] >= 4'd8)
        w_step[BIN_W+4*d +: 4] = w_step[BIN_W+4*d +: 4] - 4'd3;
    end
  end

`ifdef BCD_CHECK_EN
  logic r_err;

  always_comb begin
    w_invalid = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9)
        w_invalid = 1'b1;
    end
  end

  // err reflects the most recently accepted start only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_accept)
      r_err <= w_invalid;
  end

  assign err = r_err;
`else
  assign w_invalid = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state and datapath update; every target gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_bin_nxt   = r_bin;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_invalid) begin
            w_state_nxt = S_ERR;
          end else begin
            w_sreg_nxt  = {bcd_in, {BIN_W{1'b0}}};
            w_cnt_nxt   = '0;
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_sreg_nxt = w_step;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_bin_nxt   = w_step[BIN_W-1:0];
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        w_bin_nxt   = '0;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_bin   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_bin   <= w_bin_nxt;
    end
  end

  assign busy   = (r_state == S_SHIFT);
  assign done   = r_done;
  assign binary = r_bin;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: random and swept BCD values vs. a decimal reference model.
// Define BCD_CHECK_EN to also exercise the invalid-digit path.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic                busy;
  logic                done;
  logic [BIN_W-1:0]    binary;
  logic                err;

  int checks   = 0;
  int failures = 0;
  logic [BIN_W-1:0] exp_q[$];
  logic prev_done = 1'b0;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .binary (binary),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of the packed digits, most significant digit first.
  function automatic int ref_val(input logic [4*DIGITS-1:0] v);
    int r = 0;
    for (int d = DIGITS - 1; d >= 0; d--)
      r = r * 10 + int'(v[4*d +: 4]);
    return r;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_one_cycle", prev_done, 0);
        if (exp_q.size() == 0)
          check("spurious_done", done, 0);
        else
          check("binary", binary, exp_q.pop_front());
      end
      prev_done = done;
    end
  end

  // One conversion; optionally pulses a competing start mid-run that must be ignored.
  task automatic run_one(input logic [4*DIGITS-1:0] v, input bit intf);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    exp_q.push_back(BIN_W'(ref_val(v)));
    @(negedge clk);
    start    = 1'b0;
    bcd_in   = (4*DIGITS)'($urandom);
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (intf && lat == 3) begin
        start  = 1'b1;
        bcd_in = 12'h123;
      end else if (intf && lat == 4) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, BIN_W + 1);
    check("busy_cycles", busy_cnt, BIN_W);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4*DIGITS-1:0] v;
    int n;
    int cyc;
    int last;
    bit saw_done;

    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_binary", binary, 0);
    check("rst_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_one(12'h000, 1'b0);
    run_one(12'h999, 1'b0);
    run_one(12'h255, 1'b0);
    run_one(12'h100, 1'b0);
    run_one(12'h456, 1'b1);

    // Start held high: conversions back to back, accepted while done is high.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h987;
    repeat (3) exp_q.push_back(BIN_W'(987));
    n = 0; cyc = 0; last = 0;
    while (n < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        n++;
        if (n > 1) check("retrigger_gap", cyc - last, BIN_W + 1);
        last = cyc;
      end
    end
    start = 1'b0;
    check("retrigger_count", n, 3);

    // Reset mid-conversion aborts with no done pulse.
    run_one(12'h321, 1'b0);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h777;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_binary", binary, 0);
    check("abort_err", err, 0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);

`ifdef BCD_CHECK_EN
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h1A3;
    exp_q.push_back('0);
    @(negedge clk);
    start = 1'b0;
    check("err_set", err, 1);
    check("err_busy", busy, 0);
    @(negedge clk);
    check("err_done", done, 1);
    check("err_hold", err, 1);
    run_one(12'h042, 1'b0);
    check("err_clear", err, 0);
`endif

    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < DIGITS; d++)
        v[4*d +: 4] = 4'($urandom_range(9));
      repeat ($urandom_range(3)) @(negedge clk);
      run_one(v, 1'b0);
    end

    for (int i = 0; i < 1000; i++) begin
      v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      run_one(v, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
